mlu_serial: RTL and testbench
=============================

Name: mlu_serial

Overview:
- Parametrised, slice-serial successor to the 32-bit MLU.
- Evaluates one SLICE-bit chunk per clock, LSB first. It carries C between cycles and accumulates Z, so a WIDTH-bit operation completes in WIDTH/SLICE cycles.
- Used where a single-cycle full-width lookahead is too costly, e.g. a small microcode sequencer or address-generation side unit.
- Valid/ready request and response handshakes.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; 1 <= SLICE <= WIDTH.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- REQ_VALID  input  1  request present.
- REQ_READY  output  1  block can accept a request.
- A  input  WIDTH  operand A; sampled on request handshake.
- B  input  WIDTH  operand B; sampled on request handshake.
- OP  input  3  operation, common::MLU_* encoding.
- C_IN  input  1  carry in for MLU_ADD; ignored for other ops.
- RSP_VALID  output  1  result valid.
- RSP_READY  input  1  consumer accepts result.
- OUT  output  WIDTH  result.
- Z  output  1  OUT == 0.
- C  output  1  carry out of the MSB slice for ADD/SUB; 0 otherwise.
- N  output  1  OUT[WIDTH-1].

Behaviour:
- Reset (async, any state, including mid-run): state IDLE; REQ_READY=1; RSP_VALID=0; OUT=0; Z=0; C=0; N=0; internal slice counter and operand shift registers cleared.
- States:
  - IDLE: REQ_READY=1. On REQ_VALID&REQ_READY, latch A, B, OP and the initial carry, clear counter, go RUN.
  - RUN: REQ_READY=0. Each cycle, slice k = bits [k*SLICE +: SLICE] is evaluated and written into OUT. Carry register updates; zero-accumulator ANDs in (slice==0); counter increments. After slice WIDTH/SLICE-1, go DONE.
  - DONE: RSP_VALID=1; REQ_READY=0. On RSP_READY, go IDLE.
- Outputs: OUT, Z, C, N hold stable throughout DONE and remain unchanged in IDLE until the next run begins.
- Latency: request handshake at cycle t gives RSP_VALID at cycle t+WIDTH/SLICE+1. No back-to-back accept in the cycle of response handshake; next request earliest the following cycle.
- Initial carry:
  - ADD uses C_IN.
  - SUB forces carry=1 internally and computes A+~B+1, so OUT=A-B regardless of C_IN (new versus MLU, which required C_IN=1).
- Per-op results: AND, OR, XOR, NOT (~A), ANOT (A&~B) are bitwise, with C=0. NOP1 gives OUT=0, Z=1, C=0.
- Arithmetic is modulo 2^WIDTH. C is the carry out of bit WIDTH-1 (for SUB, C=1 means no borrow).
- Z reflects the full WIDTH result, not the last slice only.
- REQ_VALID while not READY: ignored; operand inputs need not be held after the handshake.
- Undefined OP values: none exist (3-bit, all eight encodings defined).
- SLICE==WIDTH: RUN lasts exactly one cycle.
- WIDTH%SLICE!=0: elaboration error.
- FORMAL block: asserts that in DONE, OUT/Z/C/N match a full-width reference computation of the latched operands.

Optional Feature:
- Macro: MLU_SERIAL_OVERFLOW_EN.
- Defined:
  - Adds output port V (1 bit), the signed overflow of ADD/SUB: carry into MSB XOR carry out of MSB.
  - V is 0 for logic ops, 0 at reset, and valid/held with the other flags.
- Undefined: port V absent; no extra logic.

Decomposition:
- Package common: existing MLU_* op constants; new mlu_serial_state_t enum {IDLE, RUN, DONE}.
- Sub-module mlu_serial_slice, combinational, parametrised by SLICE:
  - Inputs: A and B slices, OP, carry in.
  - Outputs: result slice, carry out, slice-zero, and MSB carry-in for the overflow feature.
- Top module owns the FSM, counter, shift registers and flag accumulation.

Test Plan:
- Defaults, ADD A=0xFFFFFFFF B=0x00000001 C_IN=0 -> OUT=0x00000000, Z=1, C=1, N=0; RSP_VALID exactly 9 cycles after handshake.
- SUB A=5 B=7 C_IN=0 -> OUT=0xFFFFFFFE, C=0, N=1, Z=0; C_IN ignored.
- WIDTH=16 SLICE=16, XOR A=0xAAAA B=0xAAAA -> OUT=0, Z=1, C=0; latency 2 cycles.
- ANOT A=0xF0F0F0F0 B=0xFF00FF00, hold RSP_READY=0 for 5 cycles -> OUT=0x00F000F0 stable, REQ_READY=0 throughout, IDLE one cycle after RSP_READY.
- Assert RST mid-RUN (slice 3 of 8) -> all outputs 0 and REQ_READY=1 immediately. A following ADD 1+2 -> OUT=3.
- With MLU_SERIAL_OVERFLOW_EN, ADD 0x7FFFFFFF+1 -> V=1, N=1, C=0; SUB 0x80000000-1 -> V=1, OUT=0x7FFFFFFF.

Source files
------------

// File: rtl/mlu_serial_pkg.sv
// mlu_serial_pkg: shared definitions for the slice-serial MLU.
//   - MLU_* : 3-bit operation encodings (all eight codes are defined).
//   - mlu_serial_state_t : sequencer states IDLE / RUN / DONE.
// Optional feature macro used by the importing files: MLU_SERIAL_OVERFLOW_EN.
package mlu_serial_pkg;

    localparam logic [2:0] MLU_AND  = 3'd0;
    localparam logic [2:0] MLU_OR   = 3'd1;
    localparam logic [2:0] MLU_XOR  = 3'd2;
    localparam logic [2:0] MLU_NOT  = 3'd3;
    localparam logic [2:0] MLU_ADD  = 3'd4;
    localparam logic [2:0] MLU_SUB  = 3'd5;
    localparam logic [2:0] MLU_ANOT = 3'd6;
    localparam logic [2:0] MLU_NOP1 = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mlu_serial_state_t;

endpackage

// File: rtl/mlu_serial_slice.sv
// mlu_serial_slice: combinational evaluation of one SLICE-bit chunk.
// Ports:
//   a, b     - operand slices
//   op       - MLU_* operation
//   cin      - carry into the slice (ADD/SUB only)
//   res      - result slice
//   cout     - carry out of the slice (0 for logic ops)
//   zero     - res == 0
//   msb_cin  - carry into the slice MSB (only with MLU_SERIAL_OVERFLOW_EN)
module mlu_serial_slice
    import mlu_serial_pkg::*;
#(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [2:0]       op,
    input  logic             cin,
    output logic [SLICE-1:0] res,
    output logic             cout,
`ifdef MLU_SERIAL_OVERFLOW_EN
    output logic             msb_cin,
`endif
    output logic             zero
);

    logic [SLICE-1:0] b_eff;
    logic [SLICE:0]   sum;
    logic             arith;

    always_comb begin
        // SUB is A + ~B + carry; the initial carry of 1 is injected by the top.
        b_eff = (op == MLU_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{SLICE{1'b0}}, cin};
        res   = '0;
        cout  = 1'b0;
        arith = 1'b0;
        unique case (op)
            MLU_ADD, MLU_SUB: begin
                res   = sum[SLICE-1:0];
                cout  = sum[SLICE];
                arith = 1'b1;
            end
            MLU_AND:  res = a & b;
            MLU_OR:   res = a | b;
            MLU_XOR:  res = a ^ b;
            MLU_NOT:  res = ~a;
            MLU_ANOT: res = a & ~b;
            MLU_NOP1: res = '0;
            default:  res = '0;
        endcase
        zero = (res == '0);
    end

`ifdef MLU_SERIAL_OVERFLOW_EN
    // Carry into the MSB recovered from the sum bit: s = a ^ b ^ c.
    assign msb_cin = arith & (res[SLICE-1] ^ a[SLICE-1] ^ b_eff[SLICE-1]);
`else
    logic unused_arith;
    assign unused_arith = arith;
`endif

endmodule

// File: rtl/mlu_serial.sv
// mlu_serial: slice-serial MLU. Evaluates SLICE bits per clock, LSB first,
// so a WIDTH-bit operation takes WIDTH/SLICE RUN cycles.
// Ports:
//   CLK, RST              - clock (rising edge), async active-high reset
//   REQ_VALID/REQ_READY   - request handshake; A, B, OP, C_IN sampled on it
//   RSP_VALID/RSP_READY   - response handshake
//   OUT, Z, C, N          - result and flags, held from DONE until next run
//   V                     - signed overflow (only with MLU_SERIAL_OVERFLOW_EN)
// Optional feature macro: MLU_SERIAL_OVERFLOW_EN.
module mlu_serial
    import mlu_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             C_IN,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             Z,
    output logic             C,
`ifdef MLU_SERIAL_OVERFLOW_EN
    output logic             V,
`endif
    output logic             N
);

    localparam int unsigned NS   = WIDTH / SLICE;
    localparam int unsigned CntW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NS - 1);

    if ((SLICE == 0) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
        $error("mlu_serial: WIDTH must be a non-zero multiple of SLICE");
    end

    mlu_serial_state_t state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              carry_q, carry_d;
    logic              zacc_q, zacc_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              z_q, z_d, c_q, c_d, n_q, n_d;

    logic [SLICE-1:0]  s_res;
    logic              s_cout, s_zero;
`ifdef MLU_SERIAL_OVERFLOW_EN
    logic              s_msb_cin;
    logic              v_q, v_d;
`endif

    mlu_serial_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a       (a_q[SLICE-1:0]),
        .b       (b_q[SLICE-1:0]),
        .op      (op_q),
        .cin     (carry_q),
        .res     (s_res),
        .cout    (s_cout),
`ifdef MLU_SERIAL_OVERFLOW_EN
        .msb_cin (s_msb_cin),
`endif
        .zero    (s_zero)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        carry_d = carry_q;
        zacc_d  = zacc_q;
        out_d   = out_q;
        z_d     = z_q;
        c_d     = c_q;
        n_d     = n_q;
`ifdef MLU_SERIAL_OVERFLOW_EN
        v_d     = v_q;
`endif
        REQ_READY = (state_q == IDLE);
        RSP_VALID = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = OP;
                    // SUB always starts with carry 1 so OUT = A - B.
                    carry_d = (OP == MLU_SUB) ? 1'b1 : ((OP == MLU_ADD) ? C_IN : 1'b0);
                    zacc_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                carry_d = s_cout;
                zacc_d  = zacc_q & s_zero;
                out_d[cnt_q*SLICE +: SLICE] = s_res;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    // Flags only change on the final slice so they stay stable otherwise.
                    z_d     = zacc_q & s_zero;
                    c_d     = s_cout;
                    n_d     = s_res[SLICE-1];
`ifdef MLU_SERIAL_OVERFLOW_EN
                    v_d     = s_msb_cin ^ s_cout;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (RSP_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= MLU_AND;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            out_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
`ifdef MLU_SERIAL_OVERFLOW_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            zacc_q  <= zacc_d;
            out_q   <= out_d;
            z_q     <= z_d;
            c_q     <= c_d;
            n_q     <= n_d;
`ifdef MLU_SERIAL_OVERFLOW_EN
            v_q     <= v_d;
`endif
        end
    end

    assign OUT = out_q;
    assign Z   = z_q;
    assign C   = c_q;
    assign N   = n_q;
`ifdef MLU_SERIAL_OVERFLOW_EN
    assign V   = v_q;
`endif

`ifdef FORMAL
    // Full-width reference of the latched request, checked whenever DONE.
    logic [WIDTH-1:0] ref_a_q, ref_b_q, ref_out;
    logic [2:0]       ref_op_q;
    logic             ref_cin_q, ref_c;
    logic [WIDTH:0]   ref_sum;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ref_a_q   <= '0;
            ref_b_q   <= '0;
            ref_op_q  <= MLU_AND;
            ref_cin_q <= 1'b0;
        end else if ((state_q == IDLE) && REQ_VALID) begin
            ref_a_q   <= A;
            ref_b_q   <= B;
            ref_op_q  <= OP;
            ref_cin_q <= carry_d;
        end
    end

    always_comb begin
        ref_sum = {1'b0, ref_a_q} + {1'b0, (ref_op_q == MLU_SUB) ? ~ref_b_q : ref_b_q}
                  + {{WIDTH{1'b0}}, ref_cin_q};
        ref_out = '0;
        ref_c   = 1'b0;
        unique case (ref_op_q)
            MLU_ADD, MLU_SUB: begin
                ref_out = ref_sum[WIDTH-1:0];
                ref_c   = ref_sum[WIDTH];
            end
            MLU_AND:  ref_out = ref_a_q & ref_b_q;
            MLU_OR:   ref_out = ref_a_q | ref_b_q;
            MLU_XOR:  ref_out = ref_a_q ^ ref_b_q;
            MLU_NOT:  ref_out = ~ref_a_q;
            MLU_ANOT: ref_out = ref_a_q & ~ref_b_q;
            default:  ref_out = '0;
        endcase
    end

    a_done_ref: assert property (@(posedge CLK) disable iff (RST)
        (state_q == DONE) |-> ((OUT == ref_out) && (Z == (ref_out == '0)) &&
                               (C == ref_c) && (N == ref_out[WIDTH-1])));
`endif

endmodule

// File: tb/tb_mlu_serial.sv
// tb_mlu_serial: directed self-checking bench for mlu_serial.
// Instantiates a default 32/4 build and a 16/16 build on a shared clock/reset.
module tb_mlu_serial;
    import mlu_serial_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_checks = 0;
    int          n_errors = 0;

    // 32-bit, 4-bit slice instance
    logic        req_valid = 1'b0, rsp_ready = 1'b0, c_in = 1'b0;
    logic        req_ready, rsp_valid, z, c, n;
    logic [31:0] a = '0, b = '0, out;
    logic [2:0]  op = MLU_AND;
`ifdef MLU_SERIAL_OVERFLOW_EN
    logic        v;
    logic        v16;
`endif

    // 16-bit, single-slice instance
    logic        req_valid16 = 1'b0, rsp_ready16 = 1'b0, c_in16 = 1'b0;
    logic        req_ready16, rsp_valid16, z16, c16, n16;
    logic [15:0] a16 = '0, b16 = '0, out16;
    logic [2:0]  op16 = MLU_AND;

    always #5 clk = ~clk;

    mlu_serial #(.WIDTH(32), .SLICE(4)) u_dut (
        .CLK       (clk),
        .RST       (rst),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .A         (a),
        .B         (b),
        .OP        (op),
        .C_IN      (c_in),
        .RSP_VALID (rsp_valid),
        .RSP_READY (rsp_ready),
        .OUT       (out),
        .Z         (z),
        .C         (c),
`ifdef MLU_SERIAL_OVERFLOW_EN
        .V         (v),
`endif
        .N         (n)
    );

    mlu_serial #(.WIDTH(16), .SLICE(16)) u_dut16 (
        .CLK       (clk),
        .RST       (rst),
        .REQ_VALID (req_valid16),
        .REQ_READY (req_ready16),
        .A         (a16),
        .B         (b16),
        .OP        (op16),
        .C_IN      (c_in16),
        .RSP_VALID (rsp_valid16),
        .RSP_READY (rsp_ready16),
        .OUT       (out16),
        .Z         (z16),
        .C         (c16),
`ifdef MLU_SERIAL_OVERFLOW_EN
        .V         (v16),
`endif
        .N         (n16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue a request on the 32-bit DUT, measure cycles to RSP_VALID (handshake cycle = 0),
    // check result and flags, optionally accept the response.
    task automatic run32(input string tag, input logic [2:0] t_op, input logic [31:0] t_a,
                         input logic [31:0] t_b, input logic t_cin, input logic [31:0] e_out,
                         input logic e_z, input logic e_c, input logic e_n, input logic e_v,
                         input bit accept);
        int lat;
        @(negedge clk);
        req_valid = 1'b1;
        op        = t_op;
        a         = t_a;
        b         = t_b;
        c_in      = t_cin;
        @(posedge clk);
        #1;
        // Operands need not be held after the handshake.
        req_valid = 1'b0;
        a         = $urandom;
        b         = $urandom;
        op        = MLU_NOP1;
        c_in      = ~t_cin;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'd9);
        check({tag, ".out"}, 64'(out), 64'(e_out));
        check({tag, ".zcn"}, {61'd0, z, c, n}, {61'd0, e_z, e_c, e_n});
`ifdef MLU_SERIAL_OVERFLOW_EN
        check({tag, ".v"}, 64'(v), 64'(e_v));
`else
        if (e_v) n_checks += 0;
`endif
        if (accept) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
        end
    endtask

    initial begin
        int lat;
        #12;
        // Reset values
        check("rst.req_ready", 64'(req_ready), 64'd1);
        check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst.out", 64'(out), 64'd0);
        check("rst.zcn", {61'd0, z, c, n}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run32("add_wrap", MLU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1, 1, 0, 0, 1'b1);
        check("add_wrap.idle_ready", 64'(req_ready), 64'd1);
        check("add_wrap.idle_valid", 64'(rsp_valid), 64'd0);
        check("add_wrap.idle_out", 64'(out), 64'd0);

        run32("sub_neg", MLU_SUB, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 0, 0, 1, 0, 1'b1);
        run32("sub_neg_cin1", MLU_SUB, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 0, 0, 1, 0, 1'b1);
        run32("sub_zero", MLU_SUB, 32'h10, 32'h10, 1'b0, 32'h0, 1, 1, 0, 0, 1'b1);
        run32("add_cin", MLU_ADD, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 32'h2222_2222, 0, 0, 0, 0,
              1'b1);
        run32("add_zmid", MLU_ADD, 32'h0001_0000, 32'h0, 1'b0, 32'h0001_0000, 0, 0, 0, 0, 1'b1);
        run32("and", MLU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 32'h0F00_0F00, 0, 0, 0, 0, 1'b1);
        run32("or", MLU_OR, 32'hF000_0000, 32'h0000_000F, 1'b0, 32'hF000_000F, 0, 0, 1, 0, 1'b1);
        run32("xor", MLU_XOR, 32'h5555_AAAA, 32'h5555_AAAA, 1'b0, 32'h0, 1, 0, 0, 0, 1'b1);
        run32("not", MLU_NOT, 32'h0000_FFFF, 32'h1234_5678, 1'b1, 32'hFFFF_0000, 0, 0, 1, 0, 1'b1);
        run32("nop1", MLU_NOP1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, 0, 0, 0, 1'b1);

        // ANOT with the consumer stalling for five cycles
        run32("anot", MLU_ANOT, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h00F0_00F0, 0, 0, 0, 0,
              1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1;   // must be ignored while busy
            op        = MLU_OR;
            a         = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
            check("anot.hold_out", 64'(out), 64'h00F0_00F0);
            check("anot.hold_rdy", {62'd0, req_ready, rsp_valid}, 64'd1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("anot.idle_rdy", {62'd0, req_ready, rsp_valid}, 64'd2);
        check("anot.idle_out", 64'(out), 64'h00F0_00F0);

        // Single-slice instance: RUN is one cycle
        @(negedge clk);
        req_valid16 = 1'b1;
        op16        = MLU_XOR;
        a16         = 16'hAAAA;
        b16         = 16'hAAAA;
        @(posedge clk);
        #1;
        req_valid16 = 1'b0;
        lat = 1;
        while (!rsp_valid16 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("w16.lat", 64'(lat), 64'd2);
        check("w16.out", 64'(out16), 64'd0);
        check("w16.zcn", {61'd0, z16, c16, n16}, 64'd4);
        @(negedge clk);
        rsp_ready16 = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready16 = 1'b0;
        check("w16.idle_rdy", 64'(req_ready16), 64'd1);

        // Asynchronous reset while slice 3 of 8 is being evaluated
        @(negedge clk);
        req_valid = 1'b1;
        op        = MLU_ADD;
        a         = 32'h1111_1111;
        b         = 32'h1111_1111;
        c_in      = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("mid.out_before", 64'(out[11:0]), 64'h222);
        rst = 1'b1;
        #1;
        check("mid.req_ready", 64'(req_ready), 64'd1);
        check("mid.rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid.out", 64'(out), 64'd0);
        check("mid.zcn", {61'd0, z, c, n}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run32("after_rst", MLU_ADD, 32'd1, 32'd2, 1'b0, 32'd3, 0, 0, 0, 0, 1'b1);

`ifdef MLU_SERIAL_OVERFLOW_EN
        run32("ovf_add", MLU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 0, 0, 1, 1, 1'b1);
        run32("ovf_sub", MLU_SUB, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 0, 1, 0, 1, 1'b1);
        run32("ovf_logic", MLU_XOR, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 0, 0, 1, 0,
              1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
